ms2xs_feeder: RTL and testbench

Stream-side host for the NTRU serial multiplier stream IP. The feeder holds one operand set of N coefficient triples (h, r, m) in local storage. On `start` it drives them as an AXI4-Stream master into the multiplier's input port, then acts as the AXI4-Stream slave for the multiplier's result stream, storing the N result coefficients for readback by the controlling logic. It is the opposite end of the multiplier's din/dout interface and uses the same beat packing.

---
 rtl/ms2xs_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_ms2xs_feeder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ms2xs_feeder.sv
// Purpose : host-side feeder for the NTRU serial multiplier stream; sends N operand beats, collects N results.
// Latency : first beat the cycle after start; done = N + R + 2 cycles after start (R = RECV cycles before result tlast).
// Backpress: master beats held stable while m_tready is low; slave side always ready while in RECV.
//
// Ports:
//   clk, reset (async, active-low)
//   wr_en/wr_addr/wr_h/wr_r/wr_m : operand memory write port (honoured in IDLE only)
//   sel, start                   : IP select field (latched at start) and launch pulse
//   busy, done                   : activity flag and one-cycle completion pulse
//   err_short/err_long/err_timeout : sticky result-stream error flags, cleared by start
//   rd_addr/rd_data              : combinational result readback
//   m_t*                         : AXI4-Stream master towards the multiplier din
//   s_t*                         : AXI4-Stream slave from the multiplier dout
// Optional feature: define MS2XS_FEEDER_TIMEOUT_EN to enable the RECV idle watchdog.

module ms2xs_feeder #(
    parameter int D_WIDTH = 32,
    parameter int N       = 11,
    parameter int q       = 2048,
    parameter int TIMEOUT = 4096,
    localparam int QW     = $clog2(q - 1),
    localparam int AW     = $clog2(N - 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [QW-1:0]      wr_h,
    input  logic [QW-1:0]      wr_r,
    input  logic [1:0]         wr_m,
    input  logic [1:0]         sel,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err_short,
    output logic               err_long,
    output logic               err_timeout,
    input  logic [AW-1:0]      rd_addr,
    output logic [QW-1:0]      rd_data,
    output logic [D_WIDTH-1:0] m_tdata,
    output logic               m_tvalid,
    output logic               m_tlast,
    input  logic               m_tready,
    input  logic [D_WIDTH-1:0] s_tdata,
    input  logic               s_tvalid,
    input  logic               s_tlast,
    output logic               s_tready
);

    // Operand word layout {h, r, m} is exactly the low 2*QW+2 bits of a beat.
    localparam int OPW = 2 * QW + 2;
    localparam int CW  = $clog2(N + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] RECV = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
    localparam logic [CW-1:0] N_C      = CW'(N);
    localparam logic [CW-1:0] NM1_C    = CW'(N - 1);
    localparam logic [AW:0]   N_A      = (AW + 1)'(N);

    logic [1:0]     state;
    logic [1:0]     sel_q;
    logic [AW-1:0]  snd_idx;
    logic [AW-1:0]  snd_nxt;
    logic [CW-1:0]  rcv_cnt;    // saturates at N; N means "beyond the last slot"
    logic           rcv_acc;

    logic [OPW-1:0] op_mem  [N];
    logic [QW-1:0]  res_mem [N];

    function automatic logic [D_WIDTH-1:0] pack(input logic [OPW-1:0] op, input logic [1:0] s);
        logic [D_WIDTH-1:0] b;
        b          = '0;
        b[25:24]   = s;
        b[OPW-1:0] = op;
        return b;
    endfunction

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign snd_nxt = snd_idx + 1'b1;
    assign rcv_acc = (state == RECV) && s_tvalid;

    // Only s_tdata[QW-1:0] carries a coefficient.
    logic unused_sdata;
    assign unused_sdata = ^s_tdata[D_WIDTH-1:QW];

`ifdef MS2XS_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] wd_cnt;
`else
    localparam int unused_timeout = TIMEOUT;
    assign err_timeout = 1'b0;
`endif

    // Operand memory: frozen outside IDLE so the beats in flight cannot change.
    always_ff @(posedge clk) begin
        if (state == IDLE && wr_en && ({1'b0, wr_addr} < N_A)) begin
            op_mem[wr_addr] <= {wr_h, wr_r, wr_m};
        end
    end

    // Result memory: no reset, only slots actually received are meaningful.
    always_ff @(posedge clk) begin
        if (rcv_acc && (rcv_cnt < N_C)) begin
            res_mem[rcv_cnt[AW-1:0]] <= s_tdata[QW-1:0];
        end
    end

    assign rd_data = ({1'b0, rd_addr} < N_A) ? res_mem[rd_addr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel_q     <= 2'b00;
            snd_idx   <= '0;
            rcv_cnt   <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            s_tready  <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
`ifdef MS2XS_FEEDER_TIMEOUT_EN
            err_timeout <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sel_q     <= sel;
                        snd_idx   <= '0;
                        rcv_cnt   <= '0;
                        err_short <= 1'b0;
                        err_long  <= 1'b0;
`ifdef MS2XS_FEEDER_TIMEOUT_EN
                        err_timeout <= 1'b0;
`endif
                        // Beat 0 is preloaded so m_tvalid rises the cycle after start.
                        m_tdata  <= pack(op_mem[0], sel);
                        m_tvalid <= 1'b1;
                        m_tlast  <= (N == 1);
                        state    <= SEND;
                    end
                end
                SEND: begin
                    // m_tvalid is always high here, so m_tready alone is the handshake.
                    if (m_tready) begin
                        if (snd_idx == LAST_IDX) begin
                            m_tdata  <= '0;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                            s_tready <= 1'b1;
                            state    <= RECV;
`ifdef MS2XS_FEEDER_TIMEOUT_EN
                            wd_cnt   <= '0;
`endif
                        end else begin
                            snd_idx <= snd_nxt;
                            m_tdata <= pack(op_mem[snd_nxt], sel_q);
                            m_tlast <= (snd_nxt == LAST_IDX);
                        end
                    end
                end
                RECV: begin
                    if (s_tvalid) begin
                        if (rcv_cnt < N_C) begin
                            rcv_cnt <= rcv_cnt + 1'b1;
                        end else begin
                            err_long <= 1'b1;
                        end
                        if (s_tlast) begin
                            if (rcv_cnt < NM1_C) begin
                                err_short <= 1'b1;
                            end
                            s_tready <= 1'b0;
                            state    <= DONE;
                        end
                    end
`ifdef MS2XS_FEEDER_TIMEOUT_EN
                    if (s_tvalid) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == TO_LAST) begin
                        err_timeout <= 1'b1;
                        s_tready    <= 1'b0;
                        state       <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ms2xs_feeder.sv
// Purpose : directed + randomized bench for ms2xs_feeder against a beat-level reference model.
// Latency : n/a (bench).
// Backpress: drives m_tready patterns (always, toggling, random) and gapped result streams.

module tb_ms2xs_feeder;

    localparam int DW = 32;
    localparam int N  = 11;
    localparam int QW = 11;
    localparam int AW = 4;
`ifdef MS2XS_FEEDER_TIMEOUT_EN
    localparam int TB_TO = 16;
`else
    localparam int TB_TO = 4096;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [QW-1:0] wr_h = '0;
    logic [QW-1:0] wr_r = '0;
    logic [1:0]    wr_m = '0;
    logic [1:0]    sel = '0;
    logic          start = 1'b0;
    logic          busy, done, err_short, err_long, err_timeout;
    logic [AW-1:0] rd_addr = '0;
    logic [QW-1:0] rd_data;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast;
    logic          m_tready = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;

    always #5 clk = ~clk;

    ms2xs_feeder #(.D_WIDTH(DW), .N(N), .q(2048), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_h(wr_h), .wr_r(wr_r), .wr_m(wr_m),
        .sel(sel), .start(start), .busy(busy), .done(done),
        .err_short(err_short), .err_long(err_long), .err_timeout(err_timeout),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t_start = 0;
    logic [DW-1:0] beat3_obs;

    // Reference model state
    logic [QW-1:0] oh  [N];
    logic [QW-1:0] orr [N];
    logic [1:0]    om  [N];
    logic [QW-1:0] exp_res [N];
    bit            written [N];
    bit            exp_short, exp_long, exp_to;

    task automatic tick;
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat from the field layout: sel at bit 24, h at bit QW+2, r at bit 2, m at bit 0.
    function automatic logic [DW-1:0] beat(input int k, input logic [1:0] s);
        return 32'(s) * 32'h0100_0000 + 32'(oh[k]) * (32'd1 << (QW + 2))
             + 32'(orr[k]) * 32'd4 + 32'(om[k]);
    endfunction

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_mtvalid"}, m_tvalid, 1'b0);
        chk({tag, "_mtlast"},  m_tlast, 1'b0);
        chk({tag, "_mtdata"},  m_tdata, 32'h0);
        chk({tag, "_stready"}, s_tready, 1'b0);
        chk({tag, "_busy"},    busy, 1'b0);
        chk({tag, "_done"},    done, 1'b0);
        chk({tag, "_eshort"},  err_short, 1'b0);
        chk({tag, "_elong"},   err_long, 1'b0);
        chk({tag, "_eto"},     err_timeout, 1'b0);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_eshort"}, err_short, exp_short);
        chk({tag, "_elong"},  err_long, exp_long);
        chk({tag, "_eto"},    err_timeout, exp_to);
    endtask

    task automatic write_ops(input bit directed);
        for (int k = 0; k < N; k++) begin
            if (directed) begin
                oh[k] = QW'(k + 1); orr[k] = QW'(2 * k); om[k] = 2'b01;
            end else begin
                oh[k] = QW'($urandom); orr[k] = QW'($urandom); om[k] = 2'($urandom_range(0, 3));
            end
            wr_en = 1'b1; wr_addr = AW'(k); wr_h = oh[k]; wr_r = orr[k]; wr_m = om[k];
            tick;
        end
        wr_en = 1'b0;
    endtask

    // mode: 0 = m_tready always 1, 1 = toggling 1/0, 2 = random.
    // poke: illegal writes and a stray start while busy (must be ignored).
    task automatic send(input int mode, input logic [1:0] s, input bit poke, input int abort_at);
        int k, cycles;
        bit r, stalled;
        logic [DW-1:0] prev;
        exp_short = 0; exp_long = 0; exp_to = 0;
        sel = s; start = 1'b1; t_start = cyc;
        tick;
        start = 1'b0; sel = ~s;
        chk("tvalid_rise", m_tvalid, 1'b1);
        k = 0; cycles = 0; stalled = 0; prev = '0;
        while (k < N && cycles < 200) begin
            chk("m_tvalid", m_tvalid, 1'b1);
            chk($sformatf("m_tdata_%0d", k), m_tdata, beat(k, s));
            chk("m_tlast", m_tlast, 32'(k == N - 1));
            chk("busy_send", busy, 1'b1);
            if (stalled) chk("stall_hold", m_tdata, prev);
            if (k == 3) beat3_obs = m_tdata;
            if (k == abort_at) begin
                #1 reset = 1'b0;
                #1 chk_reset_outs("async_rst");
                m_tready = 1'b0; wr_en = 1'b0; start = 1'b0;
                tick;
                chk_reset_outs("rst_edge");
                reset = 1'b1;
                tick;
                return;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (cycles % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            m_tready = r;
            if (poke) begin
                wr_en = 1'b1; wr_addr = AW'(k % N);
                wr_h = QW'($urandom); wr_r = QW'($urandom); wr_m = 2'($urandom);
                start = (cycles == 2);
            end
            prev = m_tdata; stalled = !r;
            tick;
            cycles++;
            if (r) k++;
        end
        wr_en = 1'b0; start = 1'b0; m_tready = 1'b0;
        chk("send_beats", k, N);
        if (mode == 0) chk("send_cycles", cycles, N);
        chk("tvalid_drop", m_tvalid, 1'b0);
        chk("stready_rise", s_tready, 1'b1);
        chk("busy_recv", busy, 1'b1);
    endtask

    task automatic recv(input int nb, input int last_at, input bit gaps, input bit directed,
                        input int exp_lat);
        logic [QW-1:0] d;
        int g;
        for (int j = 0; j < nb; j++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    s_tvalid = 1'b0;
                    chk("stready_gap", s_tready, 1'b1);
                    tick;
                end
            end
            chk("stready", s_tready, 1'b1);
            if (directed && j == 0)      d = 11'h7FF;
            else if (directed && j == 1) d = 11'h000;
            else                         d = QW'($urandom);
            s_tvalid = 1'b1; s_tdata = {21'($urandom), d}; s_tlast = (j == last_at);
            if (j < N) begin
                exp_res[j] = d; written[j] = 1;
            end else begin
                exp_long = 1;
            end
            if (j == last_at && j < N - 1) exp_short = 1;
            tick;
            if (j == last_at) break;
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("done_pulse", done, 1'b1);
        chk("stready_drop", s_tready, 1'b0);
        chk("busy_done", busy, 1'b1);
        if (exp_lat >= 0) chk("latency", cyc - t_start, exp_lat);
        tick;
        chk("done_once", done, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk_flags("recv");
        for (int i = 0; i < N; i++) begin
            if (written[i]) begin
                rd_addr = AW'(i);
                #1 chk($sformatf("rd_%0d", i), rd_data, exp_res[i]);
            end
        end
    endtask

    initial begin
        int w;
        // Reset state
        tick; tick;
        chk_reset_outs("reset");
        reset = 1'b1;
        tick;

        // Directed operands, full-rate send, directed result stream, latency N+R+2 with R=10
        write_ops(1'b1);
        send(0, 2'b01, 1'b0, -1);
        chk("beat3", beat3_obs, 32'h0100_8019);
        recv(N, N - 1, 1'b0, 1'b1, N + 10 + 2);
        rd_addr = '0;
        #1 chk("rd0_7ff", rd_data, 11'h7FF);

        // Same operands, toggling ready, illegal writes/start while busy
        send(1, 2'b01, 1'b1, -1);
        recv(N, N - 1, 1'b1, 1'b0, -1);
        // Operand memory must be untouched by the writes during SEND
        send(0, 2'b11, 1'b0, -1);
        recv(N, N - 1, 1'b0, 1'b0, -1);

        // Random operands, random backpressure, short result stream (tlast on beat 5)
        write_ops(1'b0);
        send(2, 2'($urandom), 1'b0, -1);
        recv(5, 4, 1'b1, 1'b0, -1);

        // Long result stream: 13 beats, tlast on beat 13; slot 10 keeps beat 11's data
        send(2, 2'($urandom), 1'b0, -1);
        recv(13, 12, 1'b1, 1'b0, -1);
        rd_addr = AW'(10);
        #1 chk("rd10_beat11", rd_data, exp_res[10]);

        // Reset while beat 4 is being presented, then a clean rerun from beat 0
        send(0, 2'b10, 1'b0, 4);
        chk_reset_outs("post_abort");
        send(0, 2'b10, 1'b0, -1);
        recv(N, N - 1, 1'b0, 1'b0, N + 10 + 2);

`ifdef MS2XS_FEEDER_TIMEOUT_EN
        // No result beats: watchdog fires TIMEOUT cycles after RECV entry
        send(0, 2'b01, 1'b0, -1);
        w = 0;
        while (!done && w < 100) begin
            tick;
            w++;
        end
        chk("to_cycles", w, TB_TO);
        exp_to = 1;
        chk_flags("timeout");
        tick;
        chk("to_idle", busy, 1'b0);
`else
        w = 0;
        chk("to_tied", err_timeout + w, 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
